// File: rtl/mxn_column_serializer.sv
// mxn_column_serializer: accepts an M x N frame in one handshake and emits it column by column on an M-bit lane bus
module mxn_column_serializer #(
  parameter int M = 3,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [M*N-1:0] in_frame,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [M-1:0]   out_col,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_last,
  output logic           busy
);
  localparam int CW = $clog2(N + 1);
  if (M < 1 || N < 1) begin : g_bad_params
    $error("mxn_column_serializer: M and N must both be >= 1");
  end
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [M*N-1:0] frame, frame_nx;
  logic load, hs;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= CW'(1);
      frame <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      frame <= frame_nx;
    end
  end
  assign out_valid = state == SEND;
  assign busy      = out_valid;
  assign out_last  = out_valid && cnt == CW'(N);
  assign in_ready  = state == IDLE || (out_ready && out_last);
  assign load      = in_valid && in_ready;
  assign hs        = out_valid && out_ready;
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    frame_nx = frame;
    if (load) begin
      state_nx = SEND;
      cnt_nx   = CW'(1);
      frame_nx = in_frame;
    end else if (hs) begin
      state_nx = out_last ? IDLE : SEND;
      cnt_nx   = out_last ? CW'(1) : cnt + CW'(1);
    end
  end
  // Row I of the frame occupies bits [I*N +: N]; column cnt is bit cnt-1 of each row.
  always_comb begin
    out_col = '0;
    for (int i = 0; i < M; i++) out_col[i] = frame[i*N + int'(cnt) - 1];
  end
endmodule

// File: tb/tb_mxn_column_serializer.sv
// tb_mxn_column_serializer: random and directed stimulus against a queue-of-columns reference model
module tb_mxn_column_serializer;
  localparam int M = 3;
  localparam int N = 4;
  localparam logic [11:0] FA = 12'hCA9;
  localparam logic [11:0] FB = 12'h536;
  logic clk = 0, rst_n = 0;
  logic [M*N-1:0] in_frame = '0;
  logic in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, out_last, busy;
  logic [M-1:0] out_col;
  logic [7:0] f1_frame = '0, f1_col;
  logic f1_valid = 0, f1_oready = 0, f1_iready, f1_ovalid, f1_last, f1_busy;
  int compared = 0, mismatched = 0, accepts = 0;
  logic [M-1:0] q[$];
  logic [M:0] beats[$];

  always #5 clk = ~clk;

  mxn_column_serializer #(.M(M), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_frame(in_frame), .in_valid(in_valid), .in_ready(in_ready),
    .out_col(out_col), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy));

  mxn_column_serializer #(.M(8), .N(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_frame(f1_frame), .in_valid(f1_valid), .in_ready(f1_iready),
    .out_col(f1_col), .out_valid(f1_ovalid), .out_ready(f1_oready), .out_last(f1_last), .busy(f1_busy));

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic logic [M-1:0] column(input logic [M*N-1:0] f, input int j);
    logic [M-1:0] c;
    for (int i = 0; i < M; i++) c[i] = f[i*N + j - 1];
    return c;
  endfunction

  // Model: a frame becomes N queued columns; the head is what must be on the bus.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      chk("reset_out_valid", {31'd0, out_valid}, 0);
    end else begin
      automatic bit rdy = q.size() == 0 || (q.size() == 1 && out_ready);
      chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
      chk("busy", {31'd0, busy}, {31'd0, q.size() != 0});
      chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
      if (q.size() != 0) begin
        chk("out_col", {29'd0, out_col}, {29'd0, q[0]});
        chk("out_last", {31'd0, out_last}, {31'd0, q.size() == 1});
        if (out_ready) begin
          beats.push_back({out_last, out_col});
          void'(q.pop_front());
        end
      end
      if (in_valid && rdy) begin
        accepts++;
        for (int j = 1; j <= N; j++) q.push_back(column(in_frame, j));
      end
    end
  end

  task automatic step(input logic v, input logic [M*N-1:0] f, input logic r);
    in_valid = v; in_frame = f; out_ready = r;
    @(posedge clk); #1;
  endtask

  task automatic expect_beats(input string n, input logic [M:0] exp[$]);
    chk({n, "_count"}, beats.size(), exp.size());
    for (int k = 0; k < exp.size() && k < beats.size(); k++)
      chk($sformatf("%s_beat%0d", n, k), {28'd0, beats[k]}, {28'd0, exp[k]});
    beats.delete();
  endtask

  initial begin
    #1;
    chk("rst_out_col", {29'd0, out_col}, 0);
    chk("rst_out_last", {31'd0, out_last}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
    // single frame
    beats.delete();
    step(1, FA, 1);
    repeat (5) step(0, '0, 1);
    expect_beats("single", '{4'b0001, 4'b0010, 4'b0100, 4'b1111});
    // backpressure on column 2, junk frame held on the input while stalled
    step(1, FA, 1);
    step(1, 12'hFFF, 1);
    chk("bp_in_ready", {31'd0, in_ready}, 0);
    step(1, 12'hFFF, 0);
    chk("bp_hold_col2", {29'd0, out_col}, 3'b010);
    step(1, 12'hFFF, 0);
    chk("bp_hold_col2b", {29'd0, out_col}, 3'b010);
    repeat (4) step(0, '0, 1);
    expect_beats("backpressure", '{4'b0001, 4'b0010, 4'b0100, 4'b1111});
    // back-to-back frames
    step(1, FA, 1);
    repeat (4) step(1, FB, 1);
    repeat (5) step(0, '0, 1);
    expect_beats("b2b", '{4'b0001, 4'b0010, 4'b0100, 4'b1111, 4'b0110, 4'b0011, 4'b0101, 4'b1000});
    // reset mid-frame
    step(1, FA, 1);
    step(0, '0, 1);
    step(0, '0, 1);
    rst_n = 0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 0);
    chk("midrst_out_col", {29'd0, out_col}, 0);
    @(posedge clk); #1 rst_n = 1;
    chk("postrst_in_ready", {31'd0, in_ready}, 1);
    beats.delete();
    step(1, FB, 1);
    repeat (5) step(0, '0, 1);
    expect_beats("after_reset", '{4'b0110, 4'b0011, 4'b0101, 4'b1000});
    // random stalls on both sides
    begin
      automatic int cyc = 0;
      automatic int base = accepts;
      while (accepts - base < 1000 && cyc < 40000) begin
        step(1'($urandom), 12'($urandom), 1'($urandom));
        cyc++;
      end
      chk("random_frames_done", {31'd0, accepts - base >= 1000}, 1);
      repeat (6) step(0, '0, 1);
      beats.delete();
    end
    // M=8, N=1: every beat is last, in_ready follows out_ready
    f1_valid = 1; f1_frame = 8'hA5; f1_oready = 1;
    @(posedge clk); #1;
    f1_frame = 8'h3C;
    chk("n1_col_a5", {24'd0, f1_col}, 8'hA5);
    chk("n1_last_a5", {31'd0, f1_last}, 1);
    chk("n1_in_ready", {31'd0, f1_iready}, 1);
    @(posedge clk); #1;
    f1_valid = 0;
    chk("n1_col_3c", {24'd0, f1_col}, 8'h3C);
    chk("n1_last_3c", {31'd0, f1_last}, 1);
    f1_oready = 0; #1;
    chk("n1_in_ready_stall", {31'd0, f1_iready}, 0);
    f1_oready = 1; #1;
    chk("n1_in_ready_go", {31'd0, f1_iready}, 1);
    @(posedge clk); #1;
    chk("n1_idle", {31'd0, f1_ovalid}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule
